hdmi_timing_ctrl: RTL
=====================

// Module: hdmi_timing_ctrl
// PURPOSE
//  Video timing controller that drives the RGB888/sync/DE inputs of the DVI/HDMI transmitter.
//  Generates hsync/vsync/de from parameterised raster counters and pulls pixels from a show-ahead
//  source (FIFO-style req/valid). Handles clean start/stop on frame boundaries and underflow.
//  Runs entirely in the pixel clock domain, upstream of the TMDS encoders.
// PARAMETERS
//  H_ACTIVE   1280      active pixels per line
//  H_FP       110       horizontal front porch, pixels
//  H_SYNC     40        hsync width, pixels
//  H_BP       220       horizontal back porch, pixels
//  V_ACTIVE   720       active lines per frame
//  V_FP       5         vertical front porch, lines
//  V_SYNC     5         vsync width, lines
//  V_BP       20        vertical back porch, lines
//  HS_POL     1         1 = hsync active-high, 0 = active-low
//  VS_POL     1         1 = vsync active-high, 0 = active-low
//  UNDERFLOW_COLOR 24'h0000FF  pixel sent when the source is empty during active video
// PORTS
//  pclk         in   1   pixel clock; all logic on rising edge
//  reset        in   1   asynchronous, active-high reset
//  enable       in   1   level; request video output
//  pix_req      out  1   pixel consumed this cycle (acts as FIFO rdreq)
//  pix_data     in   24  RGB888 pixel, {R,G,B}; valid in same cycle as pix_valid
//  pix_valid    in   1   source has a pixel (show-ahead, ~empty)
//  err_clr      in   1   pulse; clears underflow flag
//  video_din    out  24  RGB888 to transmitter
//  video_hsync  out  1   hsync to transmitter
//  video_vsync  out  1   vsync to transmitter
//  video_de     out  1   data enable to transmitter
//  frame_start  out  1   1-cycle pulse, aligned with first active pixel of each frame
//  running      out  1   1 while state != IDLE
//  underflow    out  1   sticky: pix_req issued while pix_valid = 0
// BEHAVIOUR
//  - Reset: state IDLE, h_cnt = v_cnt = 0, video_din = 0, video_de = 0, frame_start = 0,
//    running = 0, underflow = 0, pix_req = 0, hsync = ~HS_POL, vsync = ~VS_POL.
//  - Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H_*). v_cnt increments when h_cnt wraps;
//    v_cnt range 0..V_TOTAL-1. Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
//  - Sync: hsync active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//    vsync active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). Level set by *_POL.
//  - pix_req is combinational: state != IDLE AND active region (and pattern off, see below).
//  - Outputs registered: the pixel at (h_cnt, v_cnt) appears one clock later on video_din.
//    The same clock-later alignment applies to video_de, video_hsync, video_vsync, frame_start.
//    Latency is one clock from counter position to outputs; pix_req leads video_de by one clock.
//  - video_din = pix_data if pix_valid, else UNDERFLOW_COLOR; 0 outside active region.
//  - underflow: set when pix_req & ~pix_valid. Cleared by err_clr. Set wins over clear in the same cycle.
//  - FSM:
//    - IDLE -> RUN when enable = 1; counters start at (0,0) in the following cycle.
//    - RUN -> STOPPING when enable = 0; timing continues unchanged.
//    - STOPPING -> RUN if enable = 1 again, with no raster disturbance.
//    - STOPPING -> IDLE after h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1. Counters are then held at 0
//      and outputs take their reset values. A partial frame is never emitted.
//  - Asserting reset mid-frame immediately forces all reset values; restart begins at (0,0).
// CONFIGURATION
//  HDMI_TIMING_COLORBAR_EN defined:
//    - adds input pattern_en (1 bit).
//    - When pattern_en = 1: pix_req is held 0 and underflow is not set.
//    - When pattern_en = 1: active pixels are 8 vertical bars, each H_ACTIVE/8 wide, in this order:
//      FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
//    - pattern_en is sampled only at frame start (h=0, v=0) and held for the whole frame.
//  Not defined: no pattern_en port; the pixel source is always used.
// TESTING
//  1. reset=1 mid-frame -> next sample: de=0, din=0, hsync=0, vsync=0, running=0, pix_req=0.
//  2. enable=1, pix_valid=1, pix_data=24'h123456 -> de high for 1280 clocks per line; din=123456
//     when de=1; hsync rises 110 clocks after de falls and lasts 40; line period 1650 clocks;
//     frame_start period 1,237,500 clocks.
//  3. pix_valid=0 for one active pixel -> that output pixel = 0000FF; underflow=1 stays set;
//     err_clr pulse -> 0. Simultaneous underflow event + err_clr -> remains 1.
//  4. enable=0 at v_cnt=100 -> outputs continue through line 749; then running=0 and de stays 0.
//     enable=1 again at v_cnt=300 instead -> running never drops and the raster is unbroken.
//  5. HS_POL=0, VS_POL=0 -> idle and blanking sync = 1; sync pulses go low.
//  6. (HDMI_TIMING_COLORBAR_EN) pattern_en=1 -> pix_req=0; pixels 0..159 = FFFFFF, 160..319 = FFFF00,
//     ..., 1120..1279 = 000000. Toggling pattern_en mid-frame has no effect until the next frame.

Source files
------------

// File: rtl/hdmi_timing_ctrl.sv
// -----------------------------------------------------------------------------
// hdmi_timing_ctrl
//
// Video timing controller feeding the RGB888/sync/DE inputs of a DVI/HDMI
// transmitter. Generates hsync/vsync/de from parameterised raster counters and
// pulls pixels from a show-ahead source. Video starts and stops only on frame
// boundaries, so a partial frame is never emitted. Single clock domain (pclk).
//
// Optional feature macro: HDMI_TIMING_COLORBAR_EN
//   When defined, adds input pattern_en. A frame started with pattern_en = 1
//   shows 8 vertical colour bars and does not consume source pixels.
//
// Ports
//   pclk         in   pixel clock, rising edge
//   reset        in   asynchronous, active-high reset
//   enable       in   level, request video output
//   pix_req      out  pixel consumed this cycle (FIFO rdreq), combinational
//   pix_data     in   RGB888 {R,G,B}, valid alongside pix_valid
//   pix_valid    in   source not empty (show-ahead)
//   pattern_en   in   colour-bar select (HDMI_TIMING_COLORBAR_EN only)
//   err_clr      in   pulse, clears the underflow flag
//   video_din    out  RGB888 to transmitter
//   video_hsync  out  hsync to transmitter (polarity HS_POL)
//   video_vsync  out  vsync to transmitter (polarity VS_POL)
//   video_de     out  data enable to transmitter
//   frame_start  out  1-cycle pulse with the first active pixel of a frame
//   running      out  1 while the FSM is not idle
//   underflow    out  sticky, pixel requested while source empty
//   state_dbg    out  current FSM state
//
// Source handshake: a pixel is transferred in every cycle where pix_req = 1.
// If pix_valid = 1 in that cycle pix_data is the pixel and the source pops
// it; if pix_valid = 0 the slot is filled with UNDERFLOW_COLOR and the
// underflow flag is set. pix_req never waits for pix_valid.
//
// Pipeline: counter position (h_cnt, v_cnt) appears on the video outputs one
// clock later, so pix_req leads video_de by exactly one clock.
// -----------------------------------------------------------------------------
module hdmi_timing_ctrl #(
    parameter int          H_ACTIVE        = 1280,
    parameter int          H_FP            = 110,
    parameter int          H_SYNC          = 40,
    parameter int          H_BP            = 220,
    parameter int          V_ACTIVE        = 720,
    parameter int          V_FP            = 5,
    parameter int          V_SYNC          = 5,
    parameter int          V_BP            = 20,
    parameter bit          HS_POL          = 1'b1,
    parameter bit          VS_POL          = 1'b1,
    parameter logic [23:0] UNDERFLOW_COLOR = 24'h0000FF
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        enable,
    output logic        pix_req,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
`ifdef HDMI_TIMING_COLORBAR_EN
    input  logic        pattern_en,
`endif
    input  logic        err_clr,
    output logic [23:0] video_din,
    output logic        video_hsync,
    output logic        video_vsync,
    output logic        video_de,
    output logic        frame_start,
    output logic        running,
    output logic        underflow,
    output logic [1:0]  state_dbg
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_C   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST_C  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_ACT_C   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST_C  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_STOPPING = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;
    logic          frame_end;
    logic          frame_origin;
    logic          active;
    logic          active_run;
    logic          hs_act;
    logic          vs_act;
    logic          pattern_cur;
    logic [23:0]   pix_sel;

    assign h_last       = (h_cnt == H_LAST_C);
    assign v_last       = (v_cnt == V_LAST_C);
    assign frame_end    = h_last && v_last;
    assign frame_origin = (h_cnt == '0) && (v_cnt == '0);
    assign active       = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign active_run   = (state != S_IDLE) && active;
    assign hs_act       = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign vs_act       = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

    assign running   = (state != S_IDLE);
    assign state_dbg = state;

    // ---------------------------------------------------------------- pixel source
`ifdef HDMI_TIMING_COLORBAR_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic       pattern_q;
    logic [2:0] bar_idx;
    logic [23:0] bar_color;

    // The value at the frame origin is used directly so the first pixel of the
    // frame already follows the newly sampled selection.
    assign pattern_cur = frame_origin ? pattern_en : pattern_q;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            pattern_q <= 1'b0;
        end else if ((state != S_IDLE) && frame_origin) begin
            pattern_q <= pattern_en;
        end
    end

    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_cnt >= HW'(k * BAR_W)) begin
                bar_idx = 3'(k);
            end
        end
    end

    always_comb begin
        bar_color = 24'h000000;
        case (bar_idx)
            3'd0: bar_color = 24'hFFFFFF;
            3'd1: bar_color = 24'hFFFF00;
            3'd2: bar_color = 24'h00FFFF;
            3'd3: bar_color = 24'h00FF00;
            3'd4: bar_color = 24'hFF00FF;
            3'd5: bar_color = 24'hFF0000;
            3'd6: bar_color = 24'h0000FF;
            default: bar_color = 24'h000000;
        endcase
    end

    assign pix_sel = pattern_cur ? bar_color
                   : (pix_valid ? pix_data : UNDERFLOW_COLOR);
`else
    assign pattern_cur = 1'b0;
    assign pix_sel     = pix_valid ? pix_data : UNDERFLOW_COLOR;
`endif

    assign pix_req = active_run && !pattern_cur;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (enable) state_nxt = S_RUN;
            S_RUN:      if (!enable) state_nxt = S_STOPPING;
            S_STOPPING: begin
                if (enable) begin
                    state_nxt = S_RUN;
                end else if (frame_end) begin
                    state_nxt = S_IDLE;
                end
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------- raster
    // Counters sit at (0,0) while idle, so the first running cycle is the
    // frame origin. Leaving STOPPING at frame_end wraps them to 0 naturally.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state == S_IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------- outputs
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            video_din   <= 24'h0;
            video_de    <= 1'b0;
            video_hsync <= ~HS_POL;
            video_vsync <= ~VS_POL;
            frame_start <= 1'b0;
        end else if (state == S_IDLE) begin
            video_din   <= 24'h0;
            video_de    <= 1'b0;
            video_hsync <= ~HS_POL;
            video_vsync <= ~VS_POL;
            frame_start <= 1'b0;
        end else begin
            video_din   <= active ? pix_sel : 24'h0;
            video_de    <= active;
            video_hsync <= hs_act ? HS_POL : ~HS_POL;
            video_vsync <= vs_act ? VS_POL : ~VS_POL;
            frame_start <= frame_origin;
        end
    end

    // Set has priority over clear so an underflow coinciding with err_clr is
    // never lost.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            underflow <= 1'b0;
        end else if (pix_req && !pix_valid) begin
            underflow <= 1'b1;
        end else if (err_clr) begin
            underflow <= 1'b0;
        end
    end

endmodule
